spi_ram_arbiter: RTL and testbench

- Shares one single-port synchronous RAM between two requesters:
  - the SPI slave's command stream (rx_data/rx_valid in, tx_data/tx_valid out);
  - a local host port using a req/gnt handshake.
- Decodes the SPI 10-bit command words, holds the SPI write and read address registers, arbitrates RAM cycles and routes read data back to the correct requester.
- Sits between the SPI slave and the RAM in the SPI-RAM subsystem.

---
 rtl/spi_ram_arbiter_if.sv | 41 ++++
 rtl/spi_ram_arbiter.sv | 199 +++++++++++++++++++
 tb/tb_spi_ram_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_ram_arbiter_if.sv
// spi_ram_arbiter_if: bus bundle around the SPI/RAM arbiter.
// Carries the SPI command/response stream, the host req/gnt port and the
// single-port RAM port. The "master" modport is the arbiter's view and the
// "slave" modport is the view of whatever sits around it (SPI slave, host, RAM).
interface spi_ram_arbiter_if #(
    parameter int ADDR_SIZE = 8
);
    // SPI command stream
    logic [9:0]           rx_data;
    logic                 rx_valid;
    logic [7:0]           tx_data;
    logic                 tx_valid;
    // host port
    logic                 host_req;
    logic                 host_we;
    logic [ADDR_SIZE-1:0] host_addr;
    logic [7:0]           host_wdata;
    logic                 host_gnt;
    logic [7:0]           host_rdata;
    logic                 host_rvalid;
    // RAM port
    logic                 ram_en;
    logic                 ram_we;
    logic [ADDR_SIZE-1:0] ram_addr;
    logic [7:0]           ram_wdata;
    logic [7:0]           ram_rdata;
    // status
    logic                 spi_ovf;

    modport master (
        input  rx_data, rx_valid, host_req, host_we, host_addr, host_wdata, ram_rdata,
        output tx_data, tx_valid, host_gnt, host_rdata, host_rvalid,
               ram_en, ram_we, ram_addr, ram_wdata, spi_ovf
    );

    modport slave (
        output rx_data, rx_valid, host_req, host_we, host_addr, host_wdata, ram_rdata,
        input  tx_data, tx_valid, host_gnt, host_rdata, host_rvalid,
               ram_en, ram_we, ram_addr, ram_wdata, spi_ovf
    );
endinterface

// File: rtl/spi_ram_arbiter.sv
// spi_ram_arbiter: shares one single-port synchronous RAM between the SPI
// command stream and a local host req/gnt port.
// SPI words: [9:8] opcode (00 set wr_addr, 01 write, 10 set rd_addr, 11 read).
// One SPI access may be pending at a time; extra access commands set spi_ovf.
// Optional feature: define ARB_STATS_EN to add saturating per-requester
// grant counters (spi_acc_cnt, host_acc_cnt).
module spi_ram_arbiter #(
    parameter int ADDR_SIZE = 8,
    parameter int PRIORITY  = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    spi_ram_arbiter_if.master  bus
`ifdef ARB_STATS_EN
    ,
    output logic [15:0]        spi_acc_cnt,
    output logic [15:0]        host_acc_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, GRANT_SPI, GRANT_HOST, RD_RET} state_t;

    state_t               state_reg, state_next;

    // SPI address registers and the single pending-access slot
    logic [ADDR_SIZE-1:0] wr_addr_reg, rd_addr_reg;
    logic                 pend_valid_reg, pend_we_reg;
    logic [ADDR_SIZE-1:0] pend_addr_reg;
    logic [7:0]           pend_wdata_reg;
    logic                 spi_ovf_reg;

    // arbitration bookkeeping: fav_spi_reg=1 means SPI wins the next contention
    logic                 fav_spi_reg;
    logic                 ret_spi_reg;

    // registered outputs
    logic                 ram_en_reg, ram_we_reg, host_gnt_reg;
    logic [ADDR_SIZE-1:0] ram_addr_reg;
    logic [7:0]           ram_wdata_reg;
    logic [7:0]           tx_data_reg, host_rdata_reg;
    logic                 tx_valid_reg, host_rvalid_reg;

    logic                 grant_spi, grant_host, contend, pend_busy;
    logic [1:0]           opcode;
    logic [ADDR_SIZE-1:0] payload;

    assign opcode    = bus.rx_data[9:8];
    assign payload   = bus.rx_data[ADDR_SIZE-1:0];
    assign contend   = pend_valid_reg && bus.host_req;
    // the slot frees at the edge closing GRANT_SPI, so a new access may land then
    assign pend_busy = pend_valid_reg && (state_reg != GRANT_SPI);

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    // next-state and winner selection
    always_comb begin
        state_next = state_reg;
        grant_spi  = 1'b0;
        grant_host = 1'b0;
        case (state_reg)
            IDLE: begin
                if (contend) begin
                    if (PRIORITY == 1 || fav_spi_reg) grant_spi  = 1'b1;
                    else                              grant_host = 1'b1;
                end else if (pend_valid_reg) begin
                    grant_spi = 1'b1;
                end else if (bus.host_req) begin
                    grant_host = 1'b1;
                end
                if (grant_spi)       state_next = GRANT_SPI;
                else if (grant_host) state_next = GRANT_HOST;
            end
            // ram_we_reg holds the winner's direction during the grant cycle
            GRANT_SPI, GRANT_HOST: state_next = ram_we_reg ? IDLE : RD_RET;
            RD_RET:                state_next = IDLE;
            default:               state_next = IDLE;
        endcase
    end

    // SPI command decode and pending-slot management
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_addr_reg    <= '0;
            rd_addr_reg    <= '0;
            pend_valid_reg <= 1'b0;
            pend_we_reg    <= 1'b0;
            pend_addr_reg  <= '0;
            pend_wdata_reg <= '0;
            spi_ovf_reg    <= 1'b0;
        end else begin
            if (state_reg == GRANT_SPI) pend_valid_reg <= 1'b0;
            if (bus.rx_valid) begin
                case (opcode)
                    2'b00: wr_addr_reg <= payload;
                    2'b01: begin
                        if (pend_busy) begin
                            spi_ovf_reg <= 1'b1;
                        end else begin
                            pend_valid_reg <= 1'b1;
                            pend_we_reg    <= 1'b1;
                            pend_addr_reg  <= wr_addr_reg;
                            pend_wdata_reg <= bus.rx_data[7:0];
                        end
                    end
                    2'b10: rd_addr_reg <= payload;
                    default: begin
                        if (pend_busy) begin
                            spi_ovf_reg <= 1'b1;
                        end else begin
                            pend_valid_reg <= 1'b1;
                            pend_we_reg    <= 1'b0;
                            pend_addr_reg  <= rd_addr_reg;
                        end
                    end
                endcase
            end
        end
    end

    // RAM cycle launch, grant pulse, read-data return and round-robin pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_en_reg      <= 1'b0;
            ram_we_reg      <= 1'b0;
            ram_addr_reg    <= '0;
            ram_wdata_reg   <= '0;
            host_gnt_reg    <= 1'b0;
            tx_data_reg     <= '0;
            tx_valid_reg    <= 1'b0;
            host_rdata_reg  <= '0;
            host_rvalid_reg <= 1'b0;
            ret_spi_reg     <= 1'b0;
            fav_spi_reg     <= 1'b1;
        end else begin
            ram_en_reg      <= 1'b0;
            ram_we_reg      <= 1'b0;
            host_gnt_reg    <= 1'b0;
            tx_valid_reg    <= 1'b0;
            host_rvalid_reg <= 1'b0;
            if (grant_spi) begin
                ram_en_reg    <= 1'b1;
                ram_we_reg    <= pend_we_reg;
                ram_addr_reg  <= pend_addr_reg;
                ram_wdata_reg <= pend_wdata_reg;
                ret_spi_reg   <= 1'b1;
            end
            if (grant_host) begin
                ram_en_reg    <= 1'b1;
                ram_we_reg    <= bus.host_we;
                ram_addr_reg  <= bus.host_addr;
                ram_wdata_reg <= bus.host_wdata;
                host_gnt_reg  <= 1'b1;
                ret_spi_reg   <= 1'b0;
            end
            // pointer moves only on a real contention: favour whoever lost
            if (state_reg == IDLE && contend) fav_spi_reg <= grant_host;
            if (state_reg == RD_RET) begin
                if (ret_spi_reg) begin
                    tx_data_reg  <= bus.ram_rdata;
                    tx_valid_reg <= 1'b1;
                end else begin
                    host_rdata_reg  <= bus.ram_rdata;
                    host_rvalid_reg <= 1'b1;
                end
            end
        end
    end

`ifdef ARB_STATS_EN
    // saturating grant counters, one count per grant cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spi_acc_cnt  <= '0;
            host_acc_cnt <= '0;
        end else begin
            if (state_reg == GRANT_SPI && spi_acc_cnt != 16'hFFFF)
                spi_acc_cnt <= spi_acc_cnt + 16'd1;
            if (state_reg == GRANT_HOST && host_acc_cnt != 16'hFFFF)
                host_acc_cnt <= host_acc_cnt + 16'd1;
        end
    end
`endif

    assign bus.ram_en      = ram_en_reg;
    assign bus.ram_we      = ram_we_reg;
    assign bus.ram_addr    = ram_addr_reg;
    assign bus.ram_wdata   = ram_wdata_reg;
    assign bus.host_gnt    = host_gnt_reg;
    assign bus.host_rdata  = host_rdata_reg;
    assign bus.host_rvalid = host_rvalid_reg;
    assign bus.tx_data     = tx_data_reg;
    assign bus.tx_valid    = tx_valid_reg;
    assign bus.spi_ovf     = spi_ovf_reg;

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// tb_spi_ram_arbiter: directed scenarios followed by random SPI/host traffic,
// checked every cycle against a transaction-level model (reference memory,
// one-entry SPI slot, busy-cycle countdown and scheduled read returns).
module tb_spi_ram_arbiter;
    localparam int ADDR_SIZE = 8;
    localparam int PRIORITY  = 0;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    logic check_en = 1'b0;

    spi_ram_arbiter_if #(.ADDR_SIZE(ADDR_SIZE)) bus ();

`ifdef ARB_STATS_EN
    logic [15:0] spi_acc_cnt, host_acc_cnt;
`endif

    spi_ram_arbiter #(.ADDR_SIZE(ADDR_SIZE), .PRIORITY(PRIORITY)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef ARB_STATS_EN
        ,
        .spi_acc_cnt  (spi_acc_cnt),
        .host_acc_cnt (host_acc_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // single-port synchronous RAM with registered read; preloaded with addr^0x5A
    logic [7:0] ram_mem [256];
    bit         mem_init = 1'b0;
    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 256; i++) ram_mem[i] <= 8'(i) ^ 8'h5A;
            mem_init <= 1'b1;
        end else if (bus.ram_en) begin
            if (bus.ram_we) ram_mem[bus.ram_addr] <= bus.ram_wdata;
            else            bus.ram_rdata <= ram_mem[bus.ram_addr];
        end
    end

    // ---------------- behavioural model ----------------
    logic [7:0] ref_mem [256];
    logic [7:0] m_wr_addr, m_rd_addr, m_pend_addr, m_pend_wdata, m_ret_data;
    logic       m_pend, m_pend_we, m_ovf, m_fav_spi, m_ret_spi, m_clear_next;
    int         m_busy, m_ret_cnt, m_spi_cnt, m_host_cnt;
    logic       exp_ram_en, exp_ram_we, exp_gnt, exp_tx_valid, exp_host_rvalid;
    logic [7:0] exp_ram_addr, exp_ram_wdata, exp_tx_data, exp_host_rdata;

    task automatic model_reset();
        m_wr_addr = 0; m_rd_addr = 0; m_pend_addr = 0; m_pend_wdata = 0; m_ret_data = 0;
        m_pend = 0; m_pend_we = 0; m_ovf = 0; m_fav_spi = 1; m_ret_spi = 0; m_clear_next = 0;
        m_busy = 0; m_ret_cnt = 0; m_spi_cnt = 0; m_host_cnt = 0;
        exp_ram_en = 0; exp_ram_we = 0; exp_gnt = 0; exp_tx_valid = 0; exp_host_rvalid = 0;
        exp_ram_addr = 0; exp_ram_wdata = 0; exp_tx_data = 0; exp_host_rdata = 0;
    endtask

    // advance the model by one clock edge using the inputs present at that edge
    task automatic model_step();
        logic       old_pend, clearing, win_spi;
        logic [1:0] op;
        logic [7:0] pl;
        exp_ram_en = 0; exp_ram_we = 0; exp_gnt = 0; exp_tx_valid = 0; exp_host_rvalid = 0;
        old_pend = m_pend;
        clearing = m_clear_next;
        m_clear_next = 0;
        if (m_ret_cnt > 0) begin
            m_ret_cnt--;
            if (m_ret_cnt == 0) begin
                if (m_ret_spi) begin exp_tx_valid = 1; exp_tx_data = m_ret_data; end
                else begin exp_host_rvalid = 1; exp_host_rdata = m_ret_data; end
            end
        end
        if (m_busy > 0) begin
            m_busy--;
        end else if (old_pend || bus.host_req) begin
            if (old_pend && bus.host_req) begin
                win_spi = (PRIORITY == 1) || m_fav_spi;
                m_fav_spi = !win_spi;
            end else begin
                win_spi = old_pend;
            end
            exp_ram_en = 1;
            if (win_spi) begin
                exp_ram_we = m_pend_we; exp_ram_addr = m_pend_addr;
                if (m_pend_we) exp_ram_wdata = m_pend_wdata;
                m_clear_next = 1;
                if (m_spi_cnt < 65535) m_spi_cnt++;
            end else begin
                exp_gnt = 1; exp_ram_we = bus.host_we; exp_ram_addr = bus.host_addr;
                if (bus.host_we) exp_ram_wdata = bus.host_wdata;
                if (m_host_cnt < 65535) m_host_cnt++;
            end
            if (exp_ram_we) begin
                ref_mem[exp_ram_addr] = exp_ram_wdata;
                m_busy = 1;
            end else begin
                m_ret_cnt = 2; m_ret_spi = win_spi; m_ret_data = ref_mem[exp_ram_addr];
                m_busy = 2;
            end
        end
        if (clearing) m_pend = 0;
        if (bus.rx_valid) begin
            op = bus.rx_data[9:8];
            pl = bus.rx_data[7:0];
            case (op)
                2'd0: m_wr_addr = pl;
                2'd1: if (m_pend) m_ovf = 1;
                      else begin m_pend = 1; m_pend_we = 1; m_pend_addr = m_wr_addr; m_pend_wdata = pl; end
                2'd2: m_rd_addr = pl;
                default: if (m_pend) m_ovf = 1;
                      else begin m_pend = 1; m_pend_we = 0; m_pend_addr = m_rd_addr; end
            endcase
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // per-cycle comparison against the model
    always @(negedge clk) begin
        if (rst_n && check_en) begin
            check("ram_en", bus.ram_en, exp_ram_en);
            check("ram_we", bus.ram_we, exp_ram_we);
            check("ram_addr", bus.ram_addr, exp_ram_addr);
            if (exp_ram_en && exp_ram_we) check("ram_wdata", bus.ram_wdata, exp_ram_wdata);
            check("host_gnt", bus.host_gnt, exp_gnt);
            check("tx_valid", bus.tx_valid, exp_tx_valid);
            check("tx_data", bus.tx_data, exp_tx_data);
            check("host_rvalid", bus.host_rvalid, exp_host_rvalid);
            check("host_rdata", bus.host_rdata, exp_host_rdata);
            check("spi_ovf", bus.spi_ovf, m_ovf);
            if (bus.ram_en)
                $display("txn %0t: %s %s addr=%02h wdata=%02h", $time,
                         bus.host_gnt ? "host" : "spi ", bus.ram_we ? "wr" : "rd",
                         bus.ram_addr, bus.ram_wdata);
            if (bus.tx_valid)    $display("txn %0t: spi  rd return %02h", $time, bus.tx_data);
            if (bus.host_rvalid) $display("txn %0t: host rd return %02h", $time, bus.host_rdata);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step();
        @(negedge clk);
        bus.rx_valid = 1'b0;
        if (exp_gnt) bus.host_req = 1'b0;
    endtask

    task automatic send_rx(input logic [9:0] word);
        bus.rx_valid = 1'b1;
        bus.rx_data  = word;
        tick();
    endtask

    // raise a host request and tick until the model grants it
    task automatic host_access(input logic we, input logic [7:0] addr, input logic [7:0] wdata);
        bit got;
        got = 0;
        bus.host_req = 1'b1; bus.host_we = we; bus.host_addr = addr; bus.host_wdata = wdata;
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            if (exp_gnt) got = 1;
        end
        if (!got) begin
            errors++;
            $display("FAIL host_grant_timeout: got no grant required grant within 20 cycles");
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ram_en"}, bus.ram_en, 0);
        check({tag, "_ram_we"}, bus.ram_we, 0);
        check({tag, "_ram_addr"}, bus.ram_addr, 0);
        check({tag, "_ram_wdata"}, bus.ram_wdata, 0);
        check({tag, "_host_gnt"}, bus.host_gnt, 0);
        check({tag, "_host_rvalid"}, bus.host_rvalid, 0);
        check({tag, "_host_rdata"}, bus.host_rdata, 0);
        check({tag, "_tx_valid"}, bus.tx_valid, 0);
        check({tag, "_tx_data"}, bus.tx_data, 0);
        check({tag, "_spi_ovf"}, bus.spi_ovf, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [3:0] rr_seq;
        logic [1:0] op;
        rr_seq = 4'b1010;  // host_gnt at contention rounds 0..3 (bit r)
        rst_n = 1'b0;
        bus.rx_valid = 0; bus.rx_data = 0;
        bus.host_req = 0; bus.host_we = 0; bus.host_addr = 0; bus.host_wdata = 0;
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i) ^ 8'h5A;
        model_reset();
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        check_en = 1'b1;
        tick();

        // SPI write 0x5C to 0x2A, then read it back
        send_rx(10'h0_2A);
        send_rx(10'h1_5C);
        send_rx(10'h2_2A);
        check("t1_ram_en", bus.ram_en, 1);
        check("t1_ram_addr", bus.ram_addr, 8'h2A);
        check("t1_ram_wdata", bus.ram_wdata, 8'h5C);
        send_rx(10'h3_00);
        repeat (3) tick();
        check("t1_tx_valid", bus.tx_valid, 1);
        check("t1_tx_data", bus.tx_data, 8'h5C);
        repeat (2) tick();

        // host write then read of 0x10
        host_access(1'b1, 8'h10, 8'hA5);
        check("t2_wr_gnt", bus.host_gnt, 1);
        tick();
        host_access(1'b0, 8'h10, 8'h00);
        check("t2_rd_gnt", bus.host_gnt, 1);
        tick();
        check("t2_rvalid_early", bus.host_rvalid, 0);
        tick();
        check("t2_rvalid", bus.host_rvalid, 1);
        check("t2_rdata", bus.host_rdata, 8'hA5);
        repeat (2) tick();

        // four contentions: round-robin alternates SPI, host, SPI, host
        for (int r = 0; r < 4; r++) begin
            send_rx({2'b01, 8'h60 + 8'(r)});
            bus.host_req = 1; bus.host_we = 1; bus.host_addr = 8'h70 + 8'(r); bus.host_wdata = 8'hB0 + 8'(r);
            tick();
            check("t3_contend_en", bus.ram_en, 1);
            check("t3_contend_gnt", bus.host_gnt, rr_seq[r]);
            repeat (6) tick();
        end

        // overflow: second SPI write while the first waits behind a host read
        bus.host_req = 1; bus.host_we = 0; bus.host_addr = 8'h33;
        send_rx(10'h0_44);
        send_rx(10'h1_77);
        send_rx(10'h0_55);
        send_rx(10'h1_99);
        check("t4_ovf", bus.spi_ovf, 1);
        check("t4_ram_en", bus.ram_en, 1);
        check("t4_ram_addr", bus.ram_addr, 8'h44);
        check("t4_ram_wdata", bus.ram_wdata, 8'h77);
        repeat (4) tick();

        // reset during RD_RET of an SPI read
        send_rx(10'h3_00);
        tick();
        tick();
        check_en = 1'b0;
        rst_n = 1'b0;
        #1;
        check_all_zero("t5_reset");
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check_en = 1'b1;
        repeat (4) tick();
        send_rx(10'h3_00);
        tick();
        check("t5_rd_addr", bus.ram_addr, 8'h00);
        repeat (2) tick();
        check("t5_tx_valid", bus.tx_valid, 1);
        check("t5_tx_data", bus.tx_data, 8'h5A);
        repeat (2) tick();

        // random traffic
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 3) == 0) begin
                op = 2'($urandom_range(0, 3));
                bus.rx_valid = 1'b1;
                bus.rx_data  = {op, (op[0] == 1'b0) ? 8'($urandom_range(0, 15)) : 8'($urandom_range(0, 255))};
            end
            if (!bus.host_req && $urandom_range(0, 2) == 0) begin
                bus.host_req   = 1'b1;
                bus.host_we    = 1'($urandom_range(0, 1));
                bus.host_addr  = 8'($urandom_range(0, 15));
                bus.host_wdata = 8'($urandom_range(0, 255));
            end
            tick();
        end
        bus.host_req = 1'b0;
        repeat (10) tick();

`ifdef ARB_STATS_EN
        check("spi_acc_cnt", spi_acc_cnt, m_spi_cnt);
        check("host_acc_cnt", host_acc_cnt, m_host_cnt);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
